// File: rtl/temp_ascii_formatter.sv
// Converts a signed 1/16 degC sample to an ASCII line "sDDD.F\r\n" and streams it to uart_tx.
// Optional FMT_SEQ_EN prefixes each line with a 2-digit hex sequence number and a space.
module temp_ascii_formatter #(
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              temp_valid,
  input  logic [DATA_W-1:0] temp_data,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              fmt_busy,
  output logic              drop_pulse
);

  localparam int unsigned INT_W  = 10;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned MAG_W  = DATA_W + 1;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned ITER_W = 4;
  localparam int unsigned TMO_W  = 2;
`ifdef FMT_SEQ_EN
  localparam int unsigned PRE_BYTES = 3;
`else
  localparam int unsigned PRE_BYTES = 0;
`endif
  localparam int unsigned NUM_BYTES = PRE_BYTES + 8;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(INT_W - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_BYTES - 1);

  typedef enum logic [2:0] {IDLE, ABS, CONV, SEND, WAIT_HI, WAIT_LO} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sample, sample_nxt;
  logic              sign, sign_nxt;
  logic [INT_W-1:0]  bin, bin_nxt;
  logic [BCD_W-1:0]  bcd, bcd_nxt, bcd_adj;
  logic [3:0]        frac, frac_nxt;
  logic [ITER_W-1:0] iter, iter_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt, body_idx;
  logic [TMO_W-1:0]  tmo, tmo_nxt;
  logic              tx_start_nxt;
  logic [7:0]        tx_data_nxt;
  logic              fmt_busy_nxt;
  logic              drop_pulse_nxt;
  logic              line_done;
  logic [MAG_W-1:0]  sample_ext, mag;
  logic [7:0]        cur_byte;
`ifdef FMT_SEQ_EN
  logic [7:0]        seq_cnt;
`endif

  function automatic logic [7:0] dec_char(input logic [3:0] n);
    return 8'h30 + 8'(n);
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  // Magnitude one bit wider than the sample so the most negative value is exact.
  always_comb begin
    sample_ext = {sample[DATA_W-1], sample};
    mag        = sample[DATA_W-1] ? -sample_ext : sample_ext;
  end

  // Double-dabble correction: add 3 to every BCD digit >= 5 before shifting.
  always_comb begin
    bcd_adj = bcd;
    for (int unsigned d = 0; d < 3; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) begin
        bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
      end
    end
  end

  // Byte currently addressed by idx; prefix bytes override the body when enabled.
  always_comb begin
    body_idx = idx - IDX_W'(PRE_BYTES);
    cur_byte = 8'h00;
    case (body_idx)
      4'd0:    cur_byte = sign ? 8'h2D : 8'h2B;
      4'd1:    cur_byte = dec_char(bcd[11:8]);
      4'd2:    cur_byte = dec_char(bcd[7:4]);
      4'd3:    cur_byte = dec_char(bcd[3:0]);
      4'd4:    cur_byte = 8'h2E;
      4'd5:    cur_byte = dec_char(frac);
      4'd6:    cur_byte = 8'h0D;
      4'd7:    cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
`ifdef FMT_SEQ_EN
    if (idx == 4'd0) begin
      cur_byte = hex_char(seq_cnt[7:4]);
    end else if (idx == 4'd1) begin
      cur_byte = hex_char(seq_cnt[3:0]);
    end else if (idx == 4'd2) begin
      cur_byte = 8'h20;
    end
`endif
  end

  // Next-state and registered-output logic; the first byte is launched from the last
  // conversion cycle since it never depends on the BCD result.
  always_comb begin
    state_nxt      = state;
    sample_nxt     = sample;
    sign_nxt       = sign;
    bin_nxt        = bin;
    bcd_nxt        = bcd;
    frac_nxt       = frac;
    iter_nxt       = iter;
    idx_nxt        = idx;
    tmo_nxt        = tmo;
    tx_start_nxt   = 1'b0;
    tx_data_nxt    = tx_data;
    fmt_busy_nxt   = fmt_busy;
    drop_pulse_nxt = temp_valid && (state != IDLE);
    line_done      = 1'b0;

    case (state)
      IDLE: begin
        if (temp_valid) begin
          sample_nxt   = temp_data;
          fmt_busy_nxt = 1'b1;
          state_nxt    = ABS;
        end
      end
      ABS: begin
        sign_nxt  = sample[DATA_W-1];
        bin_nxt   = INT_W'(mag >> 4);
        frac_nxt  = 4'((8'(mag[3:0]) * 8'd10) >> 4);
        bcd_nxt   = '0;
        iter_nxt  = '0;
        idx_nxt   = '0;
        state_nxt = CONV;
      end
      CONV: begin
        {bcd_nxt, bin_nxt} = {bcd_adj, bin} << 1;
        iter_nxt = iter + 4'd1;
        if (iter == LAST_ITER) begin
          if (tx_busy) begin
            state_nxt = SEND;
          end else begin
            tx_start_nxt = 1'b1;
            tx_data_nxt  = cur_byte;
            tmo_nxt      = '0;
            state_nxt    = WAIT_HI;
          end
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_nxt = 1'b1;
          tx_data_nxt  = cur_byte;
          tmo_nxt      = '0;
          state_nxt    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_nxt = WAIT_LO;
        end else if (tmo == '1) begin
          tx_start_nxt = 1'b1;
          tmo_nxt      = '0;
        end else begin
          tmo_nxt = tmo + 2'd1;
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx == LAST_IDX) begin
            fmt_busy_nxt = 1'b0;
            line_done    = 1'b1;
            state_nxt    = IDLE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample     <= '0;
      sign       <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      frac       <= '0;
      iter       <= '0;
      idx        <= '0;
      tmo        <= '0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      fmt_busy   <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      sample     <= sample_nxt;
      sign       <= sign_nxt;
      bin        <= bin_nxt;
      bcd        <= bcd_nxt;
      frac       <= frac_nxt;
      iter       <= iter_nxt;
      idx        <= idx_nxt;
      tmo        <= tmo_nxt;
      tx_start   <= tx_start_nxt;
      tx_data    <= tx_data_nxt;
      fmt_busy   <= fmt_busy_nxt;
      drop_pulse <= drop_pulse_nxt;
    end
  end

`ifdef FMT_SEQ_EN
  // Line counter advances only on completed lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt <= 8'h00;
    end else if (line_done) begin
      seq_cnt <= seq_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_temp_ascii_formatter.sv
// Bench for temp_ascii_formatter with a behavioural uart_tx responder (4 clocks per bit).
module tb_temp_ascii_formatter;

  localparam int BUSY_CYC = 40;
`ifdef FMT_SEQ_EN
  localparam int NB = 11;
`else
  localparam int NB = 8;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        temp_valid;
  logic [11:0] temp_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        fmt_busy;
  logic        drop_pulse;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  int          busy_cnt = 0;
  int          pulses = 0;
  int          ignored = 0;
  int          ignore_target = 0;
  logic [7:0]  exp_seq = 8'h00;

  temp_ascii_formatter #(.DATA_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .temp_valid (temp_valid),
    .temp_data  (temp_data),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .fmt_busy   (fmt_busy),
    .drop_pulse (drop_pulse)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: accepts tx_start when idle, busy for one 10-bit frame.
  always @(posedge clk) begin
    if (tx_start) pulses <= pulses + 1;
    if (rst) begin
      tx_busy  <= 1'b0;
      busy_cnt <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) tx_busy <= 1'b0;
    end else if (tx_start) begin
      if (ignored < ignore_target) begin
        ignored <= ignored + 1;
      end else begin
        got.push_back(tx_data);
        tx_busy  <= 1'b1;
        busy_cnt <= BUSY_CYC;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] hex_ch(input int n);
    return (n < 10) ? 8'(48 + n) : 8'(55 + n);
  endfunction

  // Reference line built from the decimal value of the sample.
  task automatic build_exp(input logic [11:0] d);
    int v, a, ip, fr;
    v  = int'($signed(d));
    a  = (v < 0) ? -v : v;
    ip = a / 16;
    fr = ((a % 16) * 10) / 16;
    exp_q.delete();
`ifdef FMT_SEQ_EN
    exp_q.push_back(hex_ch(int'(exp_seq) / 16));
    exp_q.push_back(hex_ch(int'(exp_seq) % 16));
    exp_q.push_back(8'h20);
`endif
    exp_q.push_back((v < 0) ? 8'h2D : 8'h2B);
    exp_q.push_back(8'(48 + ip / 100));
    exp_q.push_back(8'(48 + (ip / 10) % 10));
    exp_q.push_back(8'(48 + ip % 10));
    exp_q.push_back(8'h2E);
    exp_q.push_back(8'(48 + fr));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  // One line: launch, latency, optional mid-frame drop, end-of-line timing, byte check.
  task automatic run_frame(input logic [11:0] d, input string tag, input int drop_at,
                           input bit poke_end);
    int lat, n, p0;
    build_exp(d);
    got.delete();
    lat = 0;
    @(negedge clk);
    temp_data  = d;
    temp_valid = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      temp_valid = 1'b0;
      if (c == 1) check({tag, "_busy_rise"}, 32'(fmt_busy), 32'd1);
      if (drop_at != 0 && c == drop_at) begin
        temp_valid = 1'b1;
        temp_data  = 12'($urandom);
      end
      if (drop_at != 0 && c == drop_at + 1) check({tag, "_drop_hi"}, 32'(drop_pulse), 32'd1);
      if (drop_at != 0 && c == drop_at + 2) check({tag, "_drop_lo"}, 32'(drop_pulse), 32'd0);
      if (tx_start && lat == 0) lat = c;
    end
    check({tag, "_latency"}, 32'(lat), 32'd12);
    n = 0;
    while (!(got.size() == NB && tx_busy == 1'b0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 3000), 32'd1);
    check({tag, "_busy_last"}, 32'(fmt_busy), 32'd1);
    if (poke_end) begin
      temp_valid = 1'b1;
      temp_data  = 12'($urandom);
    end
    @(negedge clk);
    temp_valid = 1'b0;
    check({tag, "_busy_fall"}, 32'(fmt_busy), 32'd0);
    check({tag, "_end_drop"}, 32'(drop_pulse), 32'(poke_end));
    check({tag, "_nbytes"}, 32'(got.size()), 32'(NB));
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s_b%0d", tag, i),
            (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp_q[i]));
    end
    exp_seq = exp_seq + 8'd1;
    if (poke_end) begin
      p0 = pulses;
      repeat (30) @(negedge clk);
      check({tag, "_no_line"}, 32'(pulses), 32'(p0));
      check({tag, "_idle"}, 32'(fmt_busy), 32'd0);
    end
  endtask

  initial begin
    int p0, n;
    rst        = 1'b1;
    temp_valid = 1'b0;
    temp_data  = 12'h000;
    repeat (3) @(negedge clk);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_fmt_busy", 32'(fmt_busy), 32'd0);
    check("rst_drop", 32'(drop_pulse), 32'd0);
    rst     = 1'b0;
    exp_seq = 8'h00;

    run_frame(12'h190, "p25", 0, 1'b0);
    run_frame(12'hFF8, "m05", 0, 1'b0);
    run_frame(12'h800, "m128", 0, 1'b0);
    run_frame(12'h7FF, "p127", 0, 1'b0);
    run_frame(12'h000, "zero", 0, 1'b0);
    run_frame(12'h190, "drop5", 5, 1'b0);
    p0 = pulses;
    repeat (30) @(negedge clk);
    check("drop5_no_line", 32'(pulses), 32'(p0));
    run_frame(12'h0A5, "edge_drop", 0, 1'b1);

    // Responder ignores the first start pulse; the formatter must re-send.
    p0 = pulses;
    ignore_target = ignored + 1;
    run_frame(12'hFF0, "retry", 0, 1'b0);
    check("retry_pulses", 32'(pulses - p0), 32'(NB + 1));

    for (int r = 0; r < 5; r++) begin
      run_frame(12'($urandom), $sformatf("rnd%0d", r), 0, 1'b0);
    end

    // Reset during the 4th byte's WAIT_LO.
    got.delete();
    @(negedge clk);
    temp_data  = 12'h190;
    temp_valid = 1'b1;
    @(negedge clk);
    temp_valid = 1'b0;
    n = 0;
    while (got.size() < 4 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach", 32'(n < 2000), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(fmt_busy), 32'd0);
    check("abort_start", 32'(tx_start), 32'd0);
    check("abort_data", 32'(tx_data), 32'h00);
    exp_seq = 8'h00;
    p0 = pulses;
    repeat (20) @(negedge clk);
    check("abort_quiet", 32'(pulses), 32'(p0));
    run_frame(12'h010, "after_rst", 0, 1'b0);

`ifdef FMT_SEQ_EN
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    exp_seq = 8'h00;
    run_frame(12'h000, "seq0", 0, 1'b0);
    run_frame(12'h000, "seq1", 0, 1'b0);
    run_frame(12'h000, "seq2", 0, 1'b0);
    force dut.seq_cnt = 8'hFF;
    @(negedge clk);
    release dut.seq_cnt;
    exp_seq = 8'hFF;
    run_frame(12'h000, "seqff", 0, 1'b0);
    run_frame(12'h000, "seq00", 0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
